reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the entry count; it SHALL be a power of two, at least 4.
REQ-002 The block SHALL have parameter WIDTH, default 2, giving allocate/complete/retire lanes per cycle, legal range 1..4.
REQ-003 The block SHALL have parameter PREG_W, default 6, giving the physical register tag width.
REQ-004 The block SHALL have parameter AREG_W, default 5, giving the architectural register index width.
REQ-005 The block SHALL use IW = log2(DEPTH) as the entry index width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have the following allocate ports:
- alloc_valid, input, WIDTH bits: per-lane allocate request.
- alloc_areg, input, WIDTH*AREG_W bits: destination architectural register.
- alloc_pd, input, WIDTH*PREG_W bits: newly renamed physical destination.
- alloc_old_pd, input, WIDTH*PREG_W bits: previous mapping, to free at retire.
- alloc_pc, input, WIDTH*32 bits: instruction PC.
- alloc_ready, output, 1 bit: at least WIDTH entries are free.
- alloc_idx, output, WIDTH*IW bits: index assigned to each lane.
REQ-009 The block SHALL have the following completion ports:
- done_valid, input, WIDTH bits: per-lane completion strobe.
- done_idx, input, WIDTH*IW bits: completing entry index.
REQ-010 The block SHALL have the following retire ports, all outputs:
- retire_valid, WIDTH bits: lane retires at the next edge.
- retire_areg, WIDTH*AREG_W bits.
- retire_pd, WIDTH*PREG_W bits.
- retire_old_pd, WIDTH*PREG_W bits.
- retire_pc, WIDTH*32 bits.
REQ-011 The block SHALL have the following status outputs:
- count, IW+1 bits: occupied entries.
- empty, 1 bit.
- full, 1 bit.

Function
REQ-012 Each entry SHALL hold v, done, areg, pd, old_pd and pc.
REQ-013 Entries SHALL be managed as a circular buffer with head (oldest) and tail (next free) pointers, both wrapping modulo DEPTH.
REQ-014 An allocate SHALL occur only when alloc_ready is 1; alloc_valid lanes asserted while alloc_ready is 0 SHALL be ignored, and the upstream stage SHALL hold them.
REQ-015 Accepted lanes SHALL take consecutive indices from tail in ascending lane order, skipping invalid lanes; alloc_idx for lane i SHALL be combinational, equal to tail plus the number of valid lanes below i, mod DEPTH.
REQ-016 A newly allocated entry SHALL be written with v=1 and done=0, and tail SHALL advance by the number of accepted lanes.
REQ-017 done_valid SHALL set done=1 on entry done_idx at the edge; a strobe to an entry with v=0 SHALL be ignored, and duplicate indices across lanes SHALL be harmless.
REQ-018 retire_valid lane k SHALL be asserted combinationally when entries head..head+k all have v=1 and done=1; retirement SHALL be strictly in order, stopping at the first not-done entry.
REQ-019 Retiring entries SHALL be cleared (v=0) at the next edge, and head SHALL advance by the retire count; there is no retire back-pressure.
REQ-020 retire_* data lanes SHALL present the head+k entry fields and SHALL be don't-care when the corresponding retire_valid bit is 0.
REQ-021 The latency from a done strobe to retire_valid SHALL be at least 1 cycle, since retire observes only the registered done bit.
REQ-022 On a cycle with simultaneous allocate and retire, count SHALL become count + nalloc - nretire.
REQ-023 alloc_ready SHALL be computed as DEPTH - count >= WIDTH, using the current count and ignoring same-cycle retires.
REQ-024 The status outputs SHALL be:
- empty = (count==0).
- full = (count==DEPTH).
- count never exceeds DEPTH.

Reset
REQ-025 Assertion of rst SHALL immediately, without waiting for clk, set head=0, tail=0, count=0, all v=0 and all done=0.
REQ-026 Reset SHALL force the outputs to alloc_ready=1, empty=1, full=0 and retire_valid=0, and in-flight allocate or done inputs during reset SHALL be discarded.

Configuration
REQ-027 When macro ROB_FLUSH_EN is defined, the block SHALL add input flush (1 bit), and flush=1 at an edge SHALL clear all v bits, set tail=head and count=0, and force retire_valid=0 in that cycle; allocate and done on the flush cycle SHALL be dropped.
REQ-028 When ROB_FLUSH_EN is undefined, the flush port and its logic SHALL be absent, and entries SHALL leave only through retirement or reset.

Verification (DEPTH=16, WIDTH=2)
REQ-029 The bench SHALL cover: reset then two-lane allocate with areg 3/4, pd 32/33 -> alloc_idx 0/1, count=2, retire_valid=00.
REQ-030 The bench SHALL cover: done_idx=1 only -> no retire; then done_idx=0 -> next cycle retire_valid=11, retire_old_pd=3/4, count 2 -> 0.
REQ-031 The bench SHALL cover: alloc_valid=10 (lane 1 only) at tail=5 -> lane 1 gets idx 5, tail=6.
REQ-032 The bench SHALL cover: fill to count=15 -> alloc_ready=0, requests ignored; retire 2 -> count=13, alloc_ready=1.
REQ-033 The bench SHALL cover: 40 allocate/retire pairs -> head and tail wrap 15 -> 0, retire order matches allocation order.
REQ-034 The bench SHALL cover: with ROB_FLUSH_EN and count=7, flush=1 -> count=0, empty=1, retire_valid=00; async rst mid-allocate -> same state immediately.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement reorder buffer: multi-lane allocate, out-of-order completion, in-order retire.
// Optional ROB_FLUSH_EN adds a flush input that discards all in-flight entries.
`timescale 1ns/1ps
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 2,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef ROB_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic [WIDTH-1:0]         alloc_valid,
    input  logic [WIDTH*AREG_W-1:0]  alloc_areg,
    input  logic [WIDTH*PREG_W-1:0]  alloc_pd,
    input  logic [WIDTH*PREG_W-1:0]  alloc_old_pd,
    input  logic [WIDTH*32-1:0]      alloc_pc,
    output logic                     alloc_ready,
    output logic [WIDTH*IW-1:0]      alloc_idx,
    input  logic [WIDTH-1:0]         done_valid,
    input  logic [WIDTH*IW-1:0]      done_idx,
    output logic [WIDTH-1:0]         retire_valid,
    output logic [WIDTH*AREG_W-1:0]  retire_areg,
    output logic [WIDTH*PREG_W-1:0]  retire_pd,
    output logic [WIDTH*PREG_W-1:0]  retire_old_pd,
    output logic [WIDTH*32-1:0]      retire_pc,
    output logic [IW:0]              count,
    output logic                     empty,
    output logic                     full
);
    localparam logic [IW+1:0] DEPTH_W = (IW+2)'(DEPTH);
    localparam logic [IW+1:0] WIDTH_W = (IW+2)'(WIDTH);

    logic [IW-1:0]     head;
    logic [IW-1:0]     tail;
    logic [DEPTH-1:0]  ent_v;
    logic [DEPTH-1:0]  ent_done;
    logic [AREG_W-1:0] ent_areg   [DEPTH];
    logic [PREG_W-1:0] ent_pd     [DEPTH];
    logic [PREG_W-1:0] ent_old_pd [DEPTH];
    logic [31:0]       ent_pc     [DEPTH];

    logic [IW-1:0]     aidx [WIDTH];
    logic [IW-1:0]     ridx [WIDTH];
    logic [IW:0]       nalloc;
    logic [IW:0]       nacc;
    logic [IW:0]       nretire;
    logic              chain;

    // Ready looks only at the registered count; same-cycle retires do not help.
    assign alloc_ready = (DEPTH_W - {1'b0, count}) >= WIDTH_W;
    assign empty       = (count == '0);
    assign full        = (count == (IW+1)'(DEPTH));

    always_comb begin
        nalloc    = '0;
        alloc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            aidx[i] = tail + nalloc[IW-1:0];
            alloc_idx[i*IW +: IW] = aidx[i];
            if (alloc_valid[i]) nalloc = nalloc + (IW+1)'(1);
        end
        nacc = alloc_ready ? nalloc : '0;
    end

    // Retire lanes form a prefix: the chain breaks at the first entry not yet done.
    always_comb begin
        retire_valid  = '0;
        retire_areg   = '0;
        retire_pd     = '0;
        retire_old_pd = '0;
        retire_pc     = '0;
        nretire       = '0;
        chain         = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            ridx[k] = head + IW'(k);
            chain   = chain & ent_v[ridx[k]] & ent_done[ridx[k]];
            retire_valid[k] = chain;
            retire_areg[k*AREG_W +: AREG_W]   = ent_areg[ridx[k]];
            retire_pd[k*PREG_W +: PREG_W]     = ent_pd[ridx[k]];
            retire_old_pd[k*PREG_W +: PREG_W] = ent_old_pd[ridx[k]];
            retire_pc[k*32 +: 32]             = ent_pc[ridx[k]];
            if (chain) nretire = nretire + (IW+1)'(1);
        end
`ifdef ROB_FLUSH_EN
        if (flush) begin
            retire_valid = '0;
            nretire      = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_v    <= '0;
            ent_done <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            ent_v    <= '0;
            ent_done <= '0;
            tail     <= head;
            count    <= '0;
        end
`endif
        else begin
            for (int j = 0; j < WIDTH; j++) begin
                if (done_valid[j] && ent_v[done_idx[j*IW +: IW]])
                    ent_done[done_idx[j*IW +: IW]] <= 1'b1;
            end
            for (int k = 0; k < WIDTH; k++) begin
                if (retire_valid[k]) begin
                    ent_v[ridx[k]]    <= 1'b0;
                    ent_done[ridx[k]] <= 1'b0;
                end
            end
            // Allocated slots are free (ready guarantees it), so they never collide with retiring ones.
            if (alloc_ready) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc_valid[i]) begin
                        ent_v[aidx[i]]    <= 1'b1;
                        ent_done[aidx[i]] <= 1'b0;
                    end
                end
            end
            head  <= head + nretire[IW-1:0];
            tail  <= tail + nacc[IW-1:0];
            count <= count + nacc - nretire;
        end
    end

    // Payload storage carries no reset; ent_v qualifies it.
    always_ff @(posedge clk) begin
        if (alloc_ready) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (alloc_valid[i]) begin
                    ent_areg[aidx[i]]   <= alloc_areg[i*AREG_W +: AREG_W];
                    ent_pd[aidx[i]]     <= alloc_pd[i*PREG_W +: PREG_W];
                    ent_old_pd[aidx[i]] <= alloc_old_pd[i*PREG_W +: PREG_W];
                    ent_pc[aidx[i]]     <= alloc_pc[i*32 +: 32];
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=16, WIDTH=2) against a queue-based reference model.
// Flush scenario is compiled in only when ROB_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_reorder_buffer;
    localparam int DEPTH = 16, WIDTH = 2, PREG_W = 6, AREG_W = 5, IW = 4;

    logic                    clk = 1'b0;
    logic                    rst;
`ifdef ROB_FLUSH_EN
    logic                    flush;
`endif
    logic [WIDTH-1:0]        alloc_valid;
    logic [WIDTH*AREG_W-1:0] alloc_areg;
    logic [WIDTH*PREG_W-1:0] alloc_pd;
    logic [WIDTH*PREG_W-1:0] alloc_old_pd;
    logic [WIDTH*32-1:0]     alloc_pc;
    logic                    alloc_ready;
    logic [WIDTH*IW-1:0]     alloc_idx;
    logic [WIDTH-1:0]        done_valid;
    logic [WIDTH*IW-1:0]     done_idx;
    logic [WIDTH-1:0]        retire_valid;
    logic [WIDTH*AREG_W-1:0] retire_areg;
    logic [WIDTH*PREG_W-1:0] retire_pd;
    logic [WIDTH*PREG_W-1:0] retire_old_pd;
    logic [WIDTH*32-1:0]     retire_pc;
    logic [IW:0]             count;
    logic                    empty;
    logic                    full;

    reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
        .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_areg(alloc_areg), .alloc_pd(alloc_pd),
        .alloc_old_pd(alloc_old_pd), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready),
        .alloc_idx(alloc_idx), .done_valid(done_valid), .done_idx(done_idx),
        .retire_valid(retire_valid), .retire_areg(retire_areg), .retire_pd(retire_pd),
        .retire_old_pd(retire_old_pd), .retire_pc(retire_pc),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old_pd;
        logic [31:0]       pc;
        bit                done;
    } ent_t;

    ent_t mq[$];
    int   m_head, m_tail;
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- reference model ----------------
    function automatic bit m_ready();
        return (DEPTH - mq.size()) >= WIDTH;
    endfunction

    function automatic int m_nret();
        int n = 0;
        while (n < WIDTH && n < mq.size() && mq[n].done) n++;
        return n;
    endfunction

    function automatic int m_aidx(input int lane);
        int off = 0;
        for (int i = 0; i < lane; i++) if (alloc_valid[i]) off++;
        return (m_tail + off) % DEPTH;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic model_edge();
        int   nret, off;
        bit   rdy;
        ent_t e;
        bit   fl = 1'b0;
`ifdef ROB_FLUSH_EN
        fl = flush;
`endif
        if (fl) begin
            mq.delete();
            m_tail = m_head;
        end else begin
            nret = m_nret();
            rdy  = m_ready();
            for (int j = 0; j < WIDTH; j++) begin
                if (done_valid[j]) begin
                    off = (int'(done_idx[j*IW +: IW]) - m_head + DEPTH) % DEPTH;
                    if (off < mq.size()) mq[off].done = 1'b1;
                end
            end
            repeat (nret) void'(mq.pop_front());
            m_head = (m_head + nret) % DEPTH;
            if (rdy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc_valid[i]) begin
                        e.areg   = alloc_areg[i*AREG_W +: AREG_W];
                        e.pd     = alloc_pd[i*PREG_W +: PREG_W];
                        e.old_pd = alloc_old_pd[i*PREG_W +: PREG_W];
                        e.pc     = alloc_pc[i*32 +: 32];
                        e.done   = 1'b0;
                        mq.push_back(e);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        alloc_valid = '0; alloc_areg = '0; alloc_pd = '0; alloc_old_pd = '0; alloc_pc = '0;
        done_valid = '0; done_idx = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic set_lane(input int lane, input logic [AREG_W-1:0] a, input logic [PREG_W-1:0] p,
                            input logic [PREG_W-1:0] o, input logic [31:0] pc);
        alloc_valid[lane]                  = 1'b1;
        alloc_areg[lane*AREG_W +: AREG_W]  = a;
        alloc_pd[lane*PREG_W +: PREG_W]    = p;
        alloc_old_pd[lane*PREG_W +: PREG_W] = o;
        alloc_pc[lane*32 +: 32]            = pc;
    endtask

    task automatic set_rand_lane(input int lane);
        set_lane(lane, AREG_W'($urandom), PREG_W'($urandom), PREG_W'($urandom), $urandom);
    endtask

    task automatic set_done(input int lane, input int idx);
        done_valid[lane]          = 1'b1;
        done_idx[lane*IW +: IW]   = IW'(idx);
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int lane;
        for (int it = 0; it < 64 && mq.size() > 0; it++) begin
            clear_in();
            lane = 0;
            for (int i = 0; i < mq.size() && lane < WIDTH; i++) begin
                if (!mq[i].done) begin
                    set_done(lane, (m_head + i) % DEPTH);
                    lane++;
                end
            end
            clk_edge();
        end
        clear_in();
        #1;
        n_checks++;
        if (count !== 0 || mq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_count: got %0d expected 0 (model %0d)", count, mq.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", alloc_ready); end
        n_checks++; if (retire_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rv: got %b expected 00", retire_valid); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic_alloc();
        clear_in();
        set_lane(0, 5'd3, 6'd32, 6'd3, 32'h100);
        set_lane(1, 5'd4, 6'd33, 6'd4, 32'h104);
        #1;
        n_checks++; if (alloc_idx !== 8'h10) begin n_fail++; $display("FAIL basic_idx: got %h expected 10", alloc_idx); end
        clk_edge();
        clear_in();
        #1;
        n_checks++; if (count !== 2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", count); end
        n_checks++; if (retire_valid !== 2'b00) begin n_fail++; $display("FAIL basic_rv: got %b expected 00", retire_valid); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b expected 0", empty); end
    endtask

    task automatic test_done_order();
        clear_in();
        set_done(0, 1);
        clk_edge();
        clear_in();
        #1;
        n_checks++; if (retire_valid !== 2'b00) begin n_fail++; $display("FAIL done1_rv: got %b expected 00", retire_valid); end
        set_done(0, 0);
        #1;
        n_checks++; if (retire_valid !== 2'b00) begin n_fail++; $display("FAIL done_latency_rv: got %b expected 00", retire_valid); end
        clk_edge();
        clear_in();
        #1;
        n_checks++; if (retire_valid !== 2'b11) begin n_fail++; $display("FAIL done0_rv: got %b expected 11", retire_valid); end
        n_checks++; if (retire_old_pd !== {6'd4, 6'd3}) begin n_fail++; $display("FAIL done_old_pd: got %h expected %h", retire_old_pd, {6'd4, 6'd3}); end
        n_checks++; if (retire_pd !== {6'd33, 6'd32}) begin n_fail++; $display("FAIL done_pd: got %h expected %h", retire_pd, {6'd33, 6'd32}); end
        n_checks++; if (count !== 2) begin n_fail++; $display("FAIL done_count_pre: got %0d expected 2", count); end
        clk_edge();
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL done_count_post: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL done_empty: got %b expected 1", empty); end
    endtask

    task automatic test_lane_skip();
        clear_in(); set_rand_lane(0); set_rand_lane(1); clk_edge();
        clear_in(); set_rand_lane(0); clk_edge();
        clear_in(); set_rand_lane(1);
        #1;
        n_checks++; if (alloc_idx[7:4] !== 4'd5) begin n_fail++; $display("FAIL skip_idx: got %0d expected 5", alloc_idx[7:4]); end
        clk_edge();
        clear_in(); set_rand_lane(0);
        #1;
        n_checks++; if (alloc_idx[3:0] !== 4'd6) begin n_fail++; $display("FAIL skip_tail: got %0d expected 6", alloc_idx[3:0]); end
        n_checks++; if (count !== 4) begin n_fail++; $display("FAIL skip_count: got %0d expected 4", count); end
        clear_in();
        drain_all();
    endtask

    task automatic test_full();
        for (int i = 0; i < 7; i++) begin
            clear_in(); set_rand_lane(0); set_rand_lane(1); clk_edge();
        end
        clear_in(); set_rand_lane(0); clk_edge();
        clear_in();
        #1;
        n_checks++; if (count !== 15) begin n_fail++; $display("FAIL full_count: got %0d expected 15", count); end
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", alloc_ready); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_flag15: got %b expected 0", full); end
        set_rand_lane(0); set_rand_lane(1);
        clk_edge();
        clear_in();
        #1;
        n_checks++; if (count !== 15) begin n_fail++; $display("FAIL full_ignore: got %0d expected 15", count); end
        set_done(0, m_head); set_done(1, (m_head + 1) % DEPTH);
        clk_edge();
        clear_in();
        #1;
        n_checks++; if (retire_valid !== 2'b11) begin n_fail++; $display("FAIL full_rv: got %b expected 11", retire_valid); end
        clk_edge();
        n_checks++; if (count !== 13) begin n_fail++; $display("FAIL full_count13: got %0d expected 13", count); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready13: got %b expected 1", alloc_ready); end
        drain_all();
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_idx;
        logic [63:0] exp_pc;
        int          start_tail;
        start_tail = m_tail;
        for (int it = 0; it < 40; it++) begin
            clear_in(); set_rand_lane(0); set_rand_lane(1);
            #1;
            exp_idx = {IW'(m_aidx(1)), IW'(m_aidx(0))};
            n_checks++; if (alloc_idx !== exp_idx) begin n_fail++; $display("FAIL wrap_idx[%0d]: got %h expected %h", it, alloc_idx, exp_idx); end
            clk_edge();
            clear_in(); set_done(0, m_head); set_done(1, (m_head + 1) % DEPTH);
            clk_edge();
            clear_in();
            #1;
            exp_pc = {mq[1].pc, mq[0].pc};
            n_checks++; if (retire_valid !== 2'b11 || retire_pc !== exp_pc) begin
                n_fail++; $display("FAIL wrap_retire[%0d]: got rv=%b pc=%h expected rv=11 pc=%h", it, retire_valid, retire_pc, exp_pc);
            end
            clk_edge();
        end
        clear_in(); set_rand_lane(0);
        #1;
        n_checks++; if (alloc_idx[3:0] !== IW'((start_tail + 80) % DEPTH)) begin
            n_fail++; $display("FAIL wrap_tail: got %0d expected %0d", alloc_idx[3:0], (start_tail + 80) % DEPTH);
        end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL wrap_count: got %0d expected 0", count); end
        clear_in();
    endtask

    task automatic test_random();
        int          nret, pdone;
        logic [1:0]  exp_rv;
        for (int it = 0; it < 400; it++) begin
            clear_in();
            pdone = ((it / 50) % 2 == 0) ? 1 : 3;
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(1) == 1) set_rand_lane(i);
                if ($urandom_range(3) < pdone) begin
                    if (mq.size() > 0 && $urandom_range(3) != 0)
                        set_done(i, (m_head + $urandom_range(mq.size() - 1)) % DEPTH);
                    else
                        set_done(i, $urandom_range(DEPTH - 1));
                end
            end
            #1;
            nret   = m_nret();
            exp_rv = 2'((1 << nret) - 1);
            n_checks++; if (count !== (IW+1)'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand_status[%0d]: got count=%0d empty=%b full=%b expected count=%0d", it, count, empty, full, mq.size());
            end
            n_checks++; if (alloc_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", it, alloc_ready, m_ready()); end
            n_checks++; if (retire_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rv[%0d]: got %b expected %b", it, retire_valid, exp_rv); end
            for (int k = 0; k < nret; k++) begin
                n_checks++;
                if (retire_pc[k*32 +: 32] !== mq[k].pc || retire_areg[k*AREG_W +: AREG_W] !== mq[k].areg ||
                    retire_pd[k*PREG_W +: PREG_W] !== mq[k].pd || retire_old_pd[k*PREG_W +: PREG_W] !== mq[k].old_pd) begin
                    n_fail++; $display("FAIL rand_retire[%0d] lane %0d: got pc=%h expected pc=%h", it, k, retire_pc[k*32 +: 32], mq[k].pc);
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (alloc_valid[i]) begin
                    n_checks++;
                    if (alloc_idx[i*IW +: IW] !== IW'(m_aidx(i))) begin
                        n_fail++; $display("FAIL rand_idx[%0d] lane %0d: got %0d expected %0d", it, i, alloc_idx[i*IW +: IW], m_aidx(i));
                    end
                end
            end
            clk_edge();
        end
        drain_all();
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        int exp_head;
        for (int i = 0; i < 3; i++) begin
            clear_in(); set_rand_lane(0); set_rand_lane(1); clk_edge();
        end
        clear_in(); set_rand_lane(0); set_done(0, m_head); clk_edge();
        clear_in();
        #1;
        n_checks++; if (count !== 7) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 7", count); end
        n_checks++; if (retire_valid !== 2'b01) begin n_fail++; $display("FAIL flush_pre_rv: got %b expected 01", retire_valid); end
        exp_head = m_head;
        flush = 1'b1;
        set_rand_lane(0); set_rand_lane(1); set_done(1, (m_head + 1) % DEPTH);
        #1;
        n_checks++; if (retire_valid !== 2'b00) begin n_fail++; $display("FAIL flush_rv: got %b expected 00", retire_valid); end
        clk_edge();
        clear_in();
        #1;
        n_checks++; if (count !== 0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_state: got count=%0d empty=%b expected 0/1", count, empty); end
        n_checks++; if (retire_valid !== 2'b00) begin n_fail++; $display("FAIL flush_rv_post: got %b expected 00", retire_valid); end
        set_rand_lane(0);
        #1;
        n_checks++; if (alloc_idx[3:0] !== IW'(exp_head)) begin n_fail++; $display("FAIL flush_tail: got %0d expected %0d", alloc_idx[3:0], exp_head); end
        clear_in();
    endtask
`endif

    task automatic test_async_reset();
        clear_in(); set_rand_lane(0); set_rand_lane(1); clk_edge();
        clear_in(); set_done(0, m_head); set_done(1, (m_head + 1) % DEPTH); clk_edge();
        clear_in(); set_rand_lane(0); set_rand_lane(1);
        #1;
        n_checks++; if (retire_valid !== 2'b11) begin n_fail++; $display("FAIL areset_pre_rv: got %b expected 11", retire_valid); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL areset_state: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
        end
        n_checks++; if (alloc_ready !== 1'b1 || retire_valid !== 2'b00) begin
            n_fail++; $display("FAIL areset_out: got ready=%b rv=%b expected 1/00", alloc_ready, retire_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_in();
        model_reset();
        #1;
        n_checks++; if (count !== 0 || alloc_idx[3:0] !== 4'd0) begin
            n_fail++; $display("FAIL areset_discard: got count=%0d idx=%0d expected 0/0", count, alloc_idx[3:0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_basic_alloc();
        test_done_order();
        test_lane_skip();
        test_full();
        test_wrap();
        test_random();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
